// File: rtl/mips_pkg.sv
// Shared MiniMIPS ALU constants and types.
// Holds the multiplier width and the sequential multiplier state encoding.
package mips_pkg;

    localparam int unsigned MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } mult_state_t;

endpackage

// File: rtl/cond_negate.sv
// Conditional two's-complement negate, width-generic.
// Negating the most negative value returns it unchanged, which reads correctly as unsigned.
module cond_negate #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             i_neg,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_neg ? (~i_data + WIDTH'(1)) : i_data;
    end

endmodule

// File: rtl/mult_seq_32bit.sv
// Iterative shift-add multiplier (mult/multu) retiring one product bit per clock.
// Signed operands are multiplied as magnitudes and the product sign is restored at the end.
module mult_seq_32bit
    import mips_pkg::*;
#(
    parameter int unsigned WIDTH = MULT_WIDTH,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi
);

    mult_state_t        r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_neg;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_res_lo;
    logic [WIDTH-1:0]   r_res_hi;

    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_product;
    logic               w_last;

    assign w_neg_a = is_signed & op_a[WIDTH-1];
    assign w_neg_b = is_signed & op_b[WIDTH-1];

    cond_negate #(
        .WIDTH (WIDTH)
    ) u_abs_a (
        .i_neg  (w_neg_a),
        .i_data (op_a),
        .o_data (w_abs_a)
    );

    cond_negate #(
        .WIDTH (WIDTH)
    ) u_abs_b (
        .i_neg  (w_neg_b),
        .i_data (op_b),
        .o_data (w_abs_b)
    );

    // Keep the add carry so the shift brings it into the accumulator MSB.
    always_comb begin
        w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_mplier[0] ? {1'b0, r_mcand} : '0);
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        w_last     = (r_cnt == CNT_W'(WIDTH - 1));
    end

    cond_negate #(
        .WIDTH (2 * WIDTH)
    ) u_neg_prod (
        .i_neg  (r_neg),
        .i_data (w_acc_next),
        .o_data (w_product)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_res_lo <= '0;
            r_res_hi <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_mcand  <= w_abs_a;
                        r_mplier <= w_abs_b;
                        r_neg    <= w_neg_a ^ w_neg_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_acc    <= w_acc_next;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state  <= DONE;
                        r_done   <= 1'b1;
                        r_res_hi <= w_product[2*WIDTH-1:WIDTH];
                        r_res_lo <= w_product[WIDTH-1:0];
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign result_lo = r_res_lo;
    assign result_hi = r_res_hi;

endmodule

// File: tb/tb_mult_seq_32bit.sv
// Scoreboard bench for mult_seq_32bit: a cycle-level model of accept/latency rules plus
// an arithmetic reference product feed a queue that a negedge monitor drains on done.
module tb_mult_seq_32bit;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        is_signed = 1'b0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    int  last_k = -1000000;
    int  next_free = 0;
    int  rst_edge = -1;
    bit  chk_en = 1'b0;
    sb_t sbq[$];
    logic [31:0] hold_hi = '0;
    logic [31:0] hold_lo = '0;

    mult_seq_32bit u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input logic s);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        if (s) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
            return sa * sb;
        end
        return {32'd0, a} * {32'd0, b};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got 0x%08h, expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Drive one cycle of inputs (sampled at the next edge k) and advance the model.
    task automatic tick(input logic st, input logic [31:0] a, input logic [31:0] b,
                        input logic s, input logic rn);
        int          k;
        logic [63:0] p;
        sb_t         e;
        @(negedge clk);
        #1;
        start     = st;
        op_a      = a;
        op_b      = b;
        is_signed = s;
        rst_n     = rn;
        k = cyc + 1;
        if (!rn) begin
            last_k    = -1000000;
            next_free = k + 1;
            rst_edge  = k;
        end else if (st && k >= next_free) begin
            p     = ref_mul(a, b, s);
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.due = k + W;
            sbq.push_back(e);
            last_k    = k;
            next_free = k + W + 2;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, $urandom, $urandom, 1'($urandom), 1'b1);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
        tick(1'b1, a, b, s, 1'b1);
        idle(W + 3);
    endtask

    function automatic logic [31:0] pick_op();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            sb_t e;
            if (cyc == rst_edge) begin
                sbq.delete();
                hold_hi = '0;
                hold_lo = '0;
            end
            check("busy", 32'(busy), 32'((cyc >= last_k) && (cyc <= last_k + W)));
            check("done", 32'(done), 32'(cyc == last_k + W));
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done at cycle %0d: got done=1, expected none", cyc);
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", cyc, e.due);
                    hold_hi = e.hi;
                    hold_lo = e.lo;
                end
            end
            check("result_hi", result_hi, hold_hi);
            check("result_lo", result_lo, hold_lo);
        end
    end

    initial begin
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        tick(1'b0, '0, '0, 1'b0, 1'b1);
        chk_en = 1'b1;
        idle(2);

        run_op(32'd7, 32'd6, 1'b0);
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1);

        // Second start lands mid-operation and must be dropped.
        tick(1'b1, 32'd2, 32'd3, 1'b0, 1'b1);
        idle(9);
        tick(1'b1, 32'd9, 32'd9, 1'b0, 1'b1);
        idle(45);

        // Reset 15 cycles into an operation, then a clean rerun.
        tick(1'b1, 32'h1234_5678, 32'h10, 1'b0, 1'b1);
        idle(14);
        tick(1'b0, '0, '0, 1'b0, 1'b0);
        idle(2);
        run_op(32'h1234_5678, 32'h10, 1'b0);

        // Start held high with operands changing every cycle.
        for (int i = 0; i < 4 * (W + 2); i++) tick(1'b1, pick_op(), pick_op(), 1'($urandom), 1'b1);
        idle(3);

        // Random sparse starts.
        for (int i = 0; i < 800; i++) begin
            tick(1'($urandom_range(0, 3) == 0), pick_op(), pick_op(), 1'($urandom), 1'b1);
        end
        idle(W + 8);

        check("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
